// File: rtl/prime_scan_if.sv
// Bundles the scan request, candidate bus and result signals of prime_scan.
// The master side is whatever requests scans and hosts the primes detector;
// the slave side is the scanner itself.
interface prime_scan_if;
  logic       start;
  logic [3:0] lo;
  logic [3:0] hi;
  logic       z;
  logic [3:0] x;
  logic       busy;
  logic       done;
  logic [4:0] count;
  logic [3:0] last_prime;
  logic       found;

  modport master (
    output start, lo, hi, z,
    input  x, busy, done, count, last_prime, found
  );

  modport slave (
    input  start, lo, hi, z,
    output x, busy, done, count, last_prime, found
  );
endinterface

// File: rtl/prime_scan.sv
// Steps a candidate value x from lo to hi, holding each value for HOLD cycles
// so an external combinational primes detector can settle, and tallies the
// candidates it flags.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for start; results of the last scan are held
//   SCAN   | driving candidates, sampling z on the last hold cycle of each
//   DONE   | one-cycle done pulse, then back to IDLE unconditionally
module prime_scan #(
  parameter int unsigned HOLD = 1
) (
  input logic         clk,
  input logic         reset,
  prime_scan_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Hold counter counts up from zero; the sample point is its last value.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] x_q, x_d;
  logic [3:0] hi_q, hi_d;
  logic [3:0] hold_q, hold_d;
  logic [4:0] count_q, count_d;
  logic [3:0] last_q, last_d;
  logic       found_q, found_d;

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= 4'd0;
      hi_q    <= 4'd0;
      hold_q  <= 4'd0;
      count_q <= 5'd0;
      last_q  <= 4'd0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      hi_q    <= hi_d;
      hold_q  <= hold_d;
      count_q <= count_d;
      last_q  <= last_d;
      found_q <= found_d;
    end
  end

  // Next-state and datapath update for the scan sequencer.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    hi_d    = hi_q;
    hold_d  = hold_q;
    count_d = count_q;
    last_d  = last_q;
    found_d = found_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x_d     = bus.lo;
          hi_d    = bus.hi;
          hold_d  = 4'd0;
          count_d = 5'd0;
          last_d  = 4'd0;
          found_d = 1'b0;
          // An empty range skips straight to the done pulse.
          state_d = (bus.lo <= bus.hi) ? S_SCAN : S_DONE;
        end
      end
      S_SCAN: begin
        if (hold_q == HOLD_LAST) begin
          if (bus.z) begin
            count_d = count_q + 5'd1;
            last_d  = x_q;
            found_d = 1'b1;
          end
          // Terminating on equality keeps x from ever wrapping past 15.
          if (x_q == hi_q) begin
            state_d = S_DONE;
          end else begin
            x_d    = x_q + 4'd1;
            hold_d = 4'd0;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.x          = x_q;
  assign bus.busy       = (state_q == S_SCAN);
  assign bus.done       = (state_q == S_DONE);
  assign bus.count      = count_q;
  assign bus.last_prime = last_q;
  assign bus.found      = found_q;

endmodule

// File: tb/tb_prime_scan.sv
// Directed bench for prime_scan: two instances (HOLD=1 and HOLD=3) share the
// same request stimulus; each has its own reference primes detector on z.
module tb_prime_scan;

  logic       clk;
  logic       reset;
  logic       start_s;
  logic [3:0] lo_s;
  logic [3:0] hi_s;

  int total = 0;
  int bad   = 0;

  // Per-instance scan measurements (index 0: HOLD=1, index 1: HOLD=3).
  int done_k  [2];
  int busy_n  [2];
  int pulses  [2];
  int xerr    [2];
  int res_cnt [2];
  int res_last[2];
  int res_fnd [2];
  int res_x   [2];

  prime_scan_if if1 ();
  prime_scan_if if3 ();

  function automatic logic is_prime(input logic [3:0] v);
    case (v)
      4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  assign if1.start = start_s;
  assign if1.lo    = lo_s;
  assign if1.hi    = hi_s;
  assign if1.z     = is_prime(if1.x);
  assign if3.start = start_s;
  assign if3.lo    = lo_s;
  assign if3.hi    = hi_s;
  assign if3.z     = is_prime(if3.x);

  prime_scan #(.HOLD(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  prime_scan #(.HOLD(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One scan on both instances: accept on a posedge, then observe 70 negedges.
  task automatic run_scan(input logic [3:0] lo, input logic [3:0] hi, input bit disturb);
    for (int i = 0; i < 2; i++) begin
      done_k[i] = 0; busy_n[i] = 0; pulses[i] = 0; xerr[i] = 0;
    end
    @(negedge clk);
    start_s = 1'b1; lo_s = lo; hi_s = hi;
    @(posedge clk);
    #1 start_s = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (if1.busy) begin
        busy_n[0]++;
        if (int'(if1.x) != int'(lo) + (k - 1)) xerr[0]++;
      end
      if (if1.done) begin
        pulses[0]++;
        if (done_k[0] == 0) done_k[0] = k;
      end
      if (if3.busy) begin
        busy_n[1]++;
        if (int'(if3.x) != int'(lo) + (k - 1) / 3) xerr[1]++;
      end
      if (if3.done) begin
        pulses[1]++;
        if (done_k[1] == 0) done_k[1] = k;
      end
      if (disturb && k == 3) begin
        start_s = 1'b1; lo_s = 4'd0; hi_s = 4'd15;
      end
      if (disturb && k == 4) start_s = 1'b0;
    end
    res_cnt[0] = int'(if1.count); res_last[0] = int'(if1.last_prime);
    res_fnd[0] = int'(if1.found); res_x[0]    = int'(if1.x);
    res_cnt[1] = int'(if3.count); res_last[1] = int'(if3.last_prime);
    res_fnd[1] = int'(if3.found); res_x[1]    = int'(if3.x);
  endtask

  task automatic chk_scan(input string tag, input int i, input int e_done, input int e_busy,
                          input int e_cnt, input int e_last, input int e_fnd, input int e_x);
    check({tag, "_done_lat"}, done_k[i], e_done);
    check({tag, "_busy_cyc"}, busy_n[i], e_busy);
    check({tag, "_pulses"},   pulses[i], 1);
    check({tag, "_xseq"},     xerr[i],   0);
    check({tag, "_count"},    res_cnt[i], e_cnt);
    check({tag, "_last"},     res_last[i], e_last);
    check({tag, "_found"},    res_fnd[i], e_fnd);
    check({tag, "_x"},        res_x[i],   e_x);
  endtask

  initial begin
    int dpulse;
    int bcyc;
    start_s = 1'b0; lo_s = 4'd0; hi_s = 4'd0;
    reset = 1'b0;
    #3;
    check("rst1_outs", int'({if1.x, if1.busy, if1.done, if1.count, if1.last_prime, if1.found}), 0);
    check("rst3_outs", int'({if3.x, if3.busy, if3.done, if3.count, if3.last_prime, if3.found}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Full range 0..15.
    run_scan(4'd0, 4'd15, 1'b0);
    chk_scan("a1", 0, 17, 16, 6, 13, 1, 15);
    chk_scan("a3", 1, 49, 48, 6, 13, 1, 15);

    // Single non-prime candidate.
    run_scan(4'd4, 4'd4, 1'b0);
    chk_scan("b1", 0, 2, 1, 0, 0, 0, 4);
    chk_scan("b3", 1, 4, 3, 0, 0, 0, 4);

    // Empty range: straight to DONE, x loaded with lo.
    run_scan(4'd9, 4'd3, 1'b0);
    chk_scan("c1", 0, 1, 0, 0, 0, 0, 9);
    chk_scan("c3", 1, 1, 0, 0, 0, 0, 9);

    // Two primes, HOLD=3 timing.
    run_scan(4'd2, 4'd3, 1'b0);
    chk_scan("d1", 0, 3, 2, 2, 3, 1, 3);
    chk_scan("d3", 1, 7, 6, 2, 3, 1, 3);

    // start and lo/hi disturbed mid-scan.
    run_scan(4'd2, 4'd7, 1'b1);
    chk_scan("e1", 0, 7, 6, 4, 7, 1, 7);
    chk_scan("e3", 1, 19, 18, 4, 7, 1, 7);

    // Reset mid-scan at x=7.
    @(negedge clk);
    start_s = 1'b1; lo_s = 4'd0; hi_s = 4'd15;
    @(posedge clk);
    #1 start_s = 1'b0;
    for (int k = 0; k < 40 && if1.x != 4'd7; k++) @(negedge clk);
    check("r_x7", int'(if1.x), 7);
    check("r_cnt_pre", int'(if1.count), 3);
    #2 reset = 1'b0;
    #1;
    check("r1_outs", int'({if1.x, if1.busy, if1.done, if1.count, if1.last_prime, if1.found}), 0);
    check("r3_outs", int'({if3.x, if3.busy, if3.done, if3.count, if3.last_prime, if3.found}), 0);
    dpulse = 0; bcyc = 0;
    repeat (3) begin
      @(negedge clk);
      dpulse += int'(if1.done) + int'(if3.done);
      bcyc   += int'(if1.busy) + int'(if3.busy);
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      dpulse += int'(if1.done) + int'(if3.done);
      bcyc   += int'(if1.busy) + int'(if3.busy);
    end
    check("r_no_done", dpulse, 0);
    check("r_idle_busy", bcyc, 0);

    run_scan(4'd0, 4'd15, 1'b0);
    chk_scan("f1", 0, 17, 16, 6, 13, 1, 15);
    chk_scan("f3", 1, 49, 48, 6, 13, 1, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
